// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator operand sequencer.
package calc_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } result_t;

endpackage

// File: rtl/calc_addsub_core.sv
// rtl/calc_addsub_core.sv - combinational 16-bit add/subtract with carry and signed overflow.
// Saturating result when CALC_SAT_EN is defined.
module calc_addsub_core
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  // Subtraction is A + ~B + 1, so carry means "no borrow".
  assign bx    = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign carry = full[WIDTH];
  assign ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

`ifdef CALC_SAT_EN
  always_comb begin
    sum = full[WIDTH-1:0];
    if (ovf) sum = a[WIDTH-1] ? SAT_NEG : SAT_POS;
  end
`else
  assign sum = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/calc_operand_seq.sv
// rtl/calc_operand_seq.sv - pairs operand words as A then B, launches one add/sub per pair.
// Optional saturation via CALC_SAT_EN (implemented in calc_addsub_core).
module calc_operand_seq
  import calc_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter bit CHAIN_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             op_sub,
  input  logic             chain,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  state_t           state, state_next;
  logic             ready_st;
  logic             xfer;
  logic [WIDTH-1:0] a_reg, b_reg, held, a_op;
  logic             sub_reg;
  logic             chain_en;
  result_t          res;
  result_t          core_res;

  assign in_ready = ready_st & rst_n;
  assign xfer     = in_valid & in_ready;
  assign a_op     = chain_en ? held : a_reg;

  calc_addsub_core u_core (
    .a     (a_op),
    .b     (b_reg),
    .sub   (sub_reg),
    .sum   (core_res.sum),
    .carry (core_res.carry),
    .ovf   (core_res.ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_st   = 1'b0;
    case (state)
      IDLE: begin
        ready_st = 1'b1;
        if (in_valid) state_next = chain ? EXEC : GOT_A;
      end
      GOT_A: begin
        ready_st = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // chain_en selects the held result as operand A for the pending operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      chain_en  <= CHAIN_DEFAULT;
      held      <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      a_reg     <= '0;
      chain_en  <= CHAIN_DEFAULT;
      held      <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (chain) begin
              b_reg    <= in_data;
              sub_reg  <= op_sub;
              chain_en <= 1'b1;
            end else begin
              a_reg    <= in_data;
              chain_en <= 1'b0;
            end
          end
        end
        GOT_A: begin
          if (xfer) begin
            b_reg   <= in_data;
            sub_reg <= op_sub;
          end
        end
        EXEC: begin
          res       <= core_res;
          held      <= core_res.sum;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = res.sum;
  assign out_carry = res.carry;
  assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_calc_operand_seq.sv
// tb/tb_calc_operand_seq.sv - scoreboard bench for calc_operand_seq (honours CALC_SAT_EN).
module tb_calc_operand_seq;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        op_sub = 1'b0;
  logic        chain = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  int   held = 0;
  bit   hold_off = 1'b0;

  calc_operand_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_sub    (op_sub),
    .chain     (chain),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out, got no handshake, expected one", name);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(int a, int b, bit sub);
    exp_t e;
    int   r, sa, sb, sr;
    r  = sub ? (a - b + 65536) : (a + b);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sr = sub ? (sa - sb) : (sa + sb);
    e.sum   = 16'(r % 65536);
    e.carry = sub ? (a >= b) : (a + b > 65535);
    e.ovf   = (sr > 32767) || (sr < -32768);
`ifdef CALC_SAT_EN
    if (e.ovf) e.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(logic [15:0] d, bit ch, bit sub);
    in_data  = d;
    chain    = ch;
    op_sub   = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sync();
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send_word");
  endtask

  task automatic do_pair(logic [15:0] a, logic [15:0] b, bit sub, exp_t e);
    send_word(a, 1'b0, 1'b0);
    send_word(b, 1'b0, sub);
    q.push_back(e);
    held = int'(e.sum);
  endtask

  task automatic do_chain(logic [15:0] b, bit sub, exp_t e);
    send_word(b, 1'b1, sub);
    q.push_back(e);
    held = int'(e.sum);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid && in_ready) begin
        sync();
        return;
      end
    end
    timeout("wait_idle");
    sync();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    sync();
    clear = 1'b0;
    held  = 0;
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  exp_t mon_prev;
  bit   mon_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_stall = 1'b0;
    end else if (out_valid) begin
      if (mon_stall) chk("hold_stable", {out_sum, out_carry, out_ovf}, mon_prev);
      if (out_ready) begin
        mon_stall = 1'b0;
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got sum 0x%0h, expected no output", out_sum);
        end else begin
          e = q.pop_front();
          chk("out_sum", out_sum, e.sum);
          chk("out_carry", out_carry, e.carry);
          chk("out_ovf", out_ovf, e.ovf);
        end
      end else begin
        mon_stall = 1'b1;
        mon_prev  = {out_sum, out_carry, out_ovf};
      end
    end else begin
      mon_stall = 1'b0;
    end
  end

  initial begin
    exp_t e;
    logic [15:0] edges [5];
    logic [15:0] a, b;
    bit sub;
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flags", {out_sum, out_carry, out_ovf}, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    sync();

    // Basic add with latency check: valid two edges after B is accepted.
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h0011, 1'b0, 1'b0);
    q.push_back('{16'h1245, 1'b0, 1'b0});
    held = 16'h1245;
    @(negedge clk);
    chk("lat_exec", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    wait_idle();

    do_pair(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
`ifdef CALC_SAT_EN
    do_pair(16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1});
`else
    do_pair(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1});
`endif
    do_pair(16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    do_chain(16'h0003, 1'b0, '{16'h0001, 1'b1, 1'b0});
    wait_idle();

    // Backpressure with a stray word offered during HOLD.
    hold_off  = 1'b1;
    out_ready = 1'b0;
    do_pair(16'h4000, 16'h0123, 1'b0, '{16'h4123, 1'b0, 1'b0});
    in_data  = 16'h5555;
    chain    = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    hold_off = 1'b0;
    wait_idle();
    do_pair(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0});
    wait_idle();

    // Clear discards partial A; clear beats a simultaneous transfer.
    send_word(16'hAAAA, 1'b0, 1'b0);
    pulse_clear();
    do_pair(16'h0001, 16'h0002, 1'b0, '{16'h0003, 1'b0, 1'b0});
    wait_idle();
    in_data  = 16'h0777;
    chain    = 1'b1;
    in_valid = 1'b1;
    pulse_clear();
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_drop_ready", in_ready, 1);
    chk("clear_drop_valid", out_valid, 0);
    sync();
    do_chain(16'h0003, 1'b0, model(0, 3, 1'b0));
    wait_idle();

    // Async reset while EXEC with a nonzero result already registered.
    chk("pre_rst_sum", out_sum, 16'h0003);
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_outputs", {out_sum, out_carry, out_ovf}, 0);
    chk("arst_in_ready", in_ready, 0);
    sync();
    rst_n = 1'b1;
    held  = 0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    sync();
    do_chain(16'h0003, 1'b0, model(0, 3, 1'b0));
    wait_idle();

    for (int n = 0; n < 80; n++) begin
      a   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        e = model(held, int'(b), sub);
        do_chain(b, sub, e);
      end else begin
        e = model(int'(a), int'(b), sub);
        do_pair(a, b, sub, e);
      end
    end
    wait_idle();
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
